// File: rtl/adt7420_pkg.sv
// Shared types and step programs for the ADT7420 transaction scheduler.
// Contents: I2C engine opcode enum, scheduler state enum, step record and
// the CFG / RD step programs (returned by step_at), register pointers.
package adt7420_pkg;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2,
      OP_STOP  = 2'd3
   } i2c_op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RSP,
      S_ABORT_ISSUE,
      S_ABORT_WAIT,
      S_DONE
   } sched_state_t;

   // Selects which byte a step places on cmd_data
   typedef enum logic [2:0] {
      SEL_ZERO,
      SEL_ADDR_W,
      SEL_ADDR_R,
      SEL_PTR_CFG,
      SEL_PTR_TEMP,
      SEL_CFG_VAL
   } data_sel_t;

   typedef struct packed {
      i2c_op_t   op;
      data_sel_t data_sel;
      logic      last;
   } step_t;

   localparam logic [7:0] PTR_CFG  = 8'h03;
   localparam logic [7:0] PTR_TEMP = 8'h00;

   // Index of the final step of each program
   localparam logic [2:0] CFG_LAST = 3'd4;
   localparam logic [2:0] RD_LAST  = 3'd7;

   function automatic step_t step_at(input logic is_rd, input logic [2:0] idx);
      step_t s;
      s = '{op: OP_STOP, data_sel: SEL_ZERO, last: 1'b0};
      if (is_rd) begin
         case (idx)
            3'd0:    s = '{op: OP_START, data_sel: SEL_ZERO,     last: 1'b0};
            3'd1:    s = '{op: OP_WRITE, data_sel: SEL_ADDR_W,   last: 1'b0};
            3'd2:    s = '{op: OP_WRITE, data_sel: SEL_PTR_TEMP, last: 1'b0};
            3'd3:    s = '{op: OP_START, data_sel: SEL_ZERO,     last: 1'b0};
            3'd4:    s = '{op: OP_WRITE, data_sel: SEL_ADDR_R,   last: 1'b0};
            3'd5:    s = '{op: OP_READ,  data_sel: SEL_ZERO,     last: 1'b0};
            3'd6:    s = '{op: OP_READ,  data_sel: SEL_ZERO,     last: 1'b1};
            default: s = '{op: OP_STOP,  data_sel: SEL_ZERO,     last: 1'b0};
         endcase
      end else begin
         case (idx)
            3'd0:    s = '{op: OP_START, data_sel: SEL_ZERO,     last: 1'b0};
            3'd1:    s = '{op: OP_WRITE, data_sel: SEL_ADDR_W,   last: 1'b0};
            3'd2:    s = '{op: OP_WRITE, data_sel: SEL_PTR_CFG,  last: 1'b0};
            3'd3:    s = '{op: OP_WRITE, data_sel: SEL_CFG_VAL,  last: 1'b0};
            default: s = '{op: OP_STOP,  data_sel: SEL_ZERO,     last: 1'b0};
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// Free-running interval timer.
// Ports: clk, rst_n (async, active-low), tick (high while the counter sits
// at TIME_TICK-1, i.e. one cycle in every TIME_TICK).
module interval_timer #(
   parameter int unsigned TIME_TICK = 100
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned  CW   = (TIME_TICK > 1) ? $clog2(TIME_TICK) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIME_TICK - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/adt7420_sched.sv
// ADT7420 transaction scheduler on a byte-level I2C command engine.
// Writes the config register once after reset, then on every interval tick
// reads the 16-bit temperature and emits it on fix_temp. Slave NACKs on
// WRITE abort with a STOP and retry up to MAX_RETRY attempts.
// Ports: cmd_valid/ready/op/data/last - command to engine;
//        rsp_valid/data/nack - engine response;
//        fix_temp_tvalid/tdata - result stream; err, overrun - pulses;
//        busy - transaction in progress.
module adt7420_sched
   import adt7420_pkg::*;
#(
   parameter int unsigned INTERVAL  = 1000000000,
   parameter int unsigned CLK_PER   = 10,
   parameter logic [6:0]  I2C_ADDR  = 7'h4B,
   parameter logic [7:0]  CFG_VALUE = 8'h00,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_op,
   output logic [7:0]  cmd_data,
   output logic        cmd_last,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_data,
   input  logic        rsp_nack,
   output logic        fix_temp_tvalid,
   output logic [15:0] fix_temp_tdata,
   output logic        err,
   output logic        overrun,
   output logic        busy
);

   localparam int unsigned TIME_TICK   = INTERVAL / CLK_PER;
   localparam logic [7:0]  MAX_RETRY_B = 8'(MAX_RETRY);

   logic tick;

   interval_timer #(.TIME_TICK(TIME_TICK)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   sched_state_t state_q, state_d;
   logic [2:0]   step_q, step_d;
   logic [7:0]   retry_q, retry_d;
   logic [7:0]   msb_q, msb_d, lsb_q, lsb_d;
   logic         is_rd_q, is_rd_d;
   logic         cfg_done_q, cfg_done_d;
   logic         cfg_wait_q, cfg_wait_d;   // CFG gave up: hold off until next tick
   logic         pending_q, pending_d;
   logic         cmd_valid_d, cmd_last_d, tvalid_d, err_d, overrun_d;
   logic [1:0]   cmd_op_d;
   logic [7:0]   cmd_data_d;
   logic [15:0]  tdata_d;
   logic         rd_start;
   step_t        cur;
   logic [7:0]   cur_byte;
   logic [15:0]  raw;

   assign cur = step_at(is_rd_q, step_q);
   assign raw = {msb_q, lsb_q};

   always_comb begin
      cur_byte = '0;
      case (cur.data_sel)
         SEL_ADDR_W:   cur_byte = {I2C_ADDR, 1'b0};
         SEL_ADDR_R:   cur_byte = {I2C_ADDR, 1'b1};
         SEL_PTR_CFG:  cur_byte = PTR_CFG;
         SEL_PTR_TEMP: cur_byte = PTR_TEMP;
         SEL_CFG_VAL:  cur_byte = CFG_VALUE;
         default:      cur_byte = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      retry_d     = retry_q;
      msb_d       = msb_q;
      lsb_d       = lsb_q;
      is_rd_d     = is_rd_q;
      cfg_done_d  = cfg_done_q;
      cfg_wait_d  = cfg_wait_q & ~tick;
      cmd_valid_d = 1'b0;
      cmd_op_d    = cmd_op;
      cmd_data_d  = cmd_data;
      cmd_last_d  = cmd_last;
      tvalid_d    = 1'b0;
      tdata_d     = fix_temp_tdata;
      err_d       = 1'b0;

      // A tick coinciding with the RD-start clear re-arms the flag
      rd_start  = (state_q == S_IDLE) && pending_q && cfg_done_q;
      pending_d = tick | (pending_q & ~rd_start);
      overrun_d = tick & pending_q & ~rd_start;

      case (state_q)
         S_IDLE: begin
            if (pending_q || (!cfg_done_q && !cfg_wait_q)) begin
               state_d = S_ISSUE;
               step_d  = '0;
               is_rd_d = cfg_done_q;
            end
         end
         S_ISSUE: begin
            // cmd_valid rises one cycle after entry so op/data are already stable
            cmd_op_d   = cur.op;
            cmd_data_d = cur_byte;
            cmd_last_d = cur.last;
            if (cmd_valid && cmd_ready)
               state_d = S_WAIT_RSP;
            else
               cmd_valid_d = 1'b1;
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               if (cur.op == OP_WRITE && rsp_nack) begin
                  state_d = S_ABORT_ISSUE;
               end else begin
                  if (cur.op == OP_READ) begin
                     if (cur.last) lsb_d = rsp_data;
                     else          msb_d = rsp_data;
                  end
                  if (step_q == (is_rd_q ? RD_LAST : CFG_LAST)) begin
                     state_d = S_DONE;
                  end else begin
                     step_d  = step_q + 3'd1;
                     state_d = S_ISSUE;
                  end
               end
            end
         end
         S_ABORT_ISSUE: begin
            cmd_op_d   = OP_STOP;
            cmd_data_d = '0;
            cmd_last_d = 1'b0;
            if (cmd_valid && cmd_ready)
               state_d = S_ABORT_WAIT;
            else
               cmd_valid_d = 1'b1;
         end
         S_ABORT_WAIT: begin
            if (rsp_valid) begin
               if (retry_q + 8'd1 < MAX_RETRY_B) begin
                  retry_d = retry_q + 8'd1;
                  step_d  = '0;
                  state_d = S_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  retry_d = '0;
                  state_d = S_IDLE;
                  if (!is_rd_q) cfg_wait_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (is_rd_q) begin
               tdata_d  = CFG_VALUE[7] ? raw : (raw >> 3);
               tvalid_d = 1'b1;
            end else begin
               cfg_done_d = 1'b1;
            end
            retry_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         step_q          <= '0;
         retry_q         <= '0;
         msb_q           <= '0;
         lsb_q           <= '0;
         is_rd_q         <= 1'b0;
         cfg_done_q      <= 1'b0;
         cfg_wait_q      <= 1'b0;
         pending_q       <= 1'b0;
         cmd_valid       <= 1'b0;
         cmd_op          <= '0;
         cmd_data        <= '0;
         cmd_last        <= 1'b0;
         fix_temp_tvalid <= 1'b0;
         fix_temp_tdata  <= '0;
         err             <= 1'b0;
         overrun         <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state_q         <= state_d;
         step_q          <= step_d;
         retry_q         <= retry_d;
         msb_q           <= msb_d;
         lsb_q           <= lsb_d;
         is_rd_q         <= is_rd_d;
         cfg_done_q      <= cfg_done_d;
         cfg_wait_q      <= cfg_wait_d;
         pending_q       <= pending_d;
         cmd_valid       <= cmd_valid_d;
         cmd_op          <= cmd_op_d;
         cmd_data        <= cmd_data_d;
         cmd_last        <= cmd_last_d;
         fix_temp_tvalid <= tvalid_d;
         fix_temp_tdata  <= tdata_d;
         err             <= err_d;
         overrun         <= overrun_d;
         busy            <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_adt7420_sched.sv
// Scoreboard bench for adt7420_sched: stimulus pushes expected commands and
// results into queues; monitors pop and compare on each handshake / strobe.
// A second instance with CFG_VALUE=0x80 checks the 16-bit result format.
`timescale 1ns/1ps
module tb_adt7420_sched;

   localparam int unsigned TT = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   int          nack_left = 0;
   logic [7:0]  rd_msb = 8'h00, rd_lsb = 8'h00;

   logic        cmd_valid, cmd_ready, cmd_last, tvalid, err, overrun, busy;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [15:0] tdata;
   logic        rsp_valid = 1'b0, rsp_nack = 1'b0;
   logic [7:0]  rsp_data = 8'h00;

   logic        cmd_valid_b, cmd_last_b, tvalid_b, err_b, overrun_b, busy_b;
   logic        cmd_ready_b;
   logic [1:0]  cmd_op_b;
   logic [7:0]  cmd_data_b;
   logic [15:0] tdata_b;
   logic        rsp_valid_b = 1'b0, rsp_nack_b = 1'b0;
   logic [7:0]  rsp_data_b = 8'h00;

   assign cmd_ready   = ~stall;
   assign cmd_ready_b = 1'b1;

   adt7420_sched #(.INTERVAL(TT * 10), .CLK_PER(10), .I2C_ADDR(7'h4B),
                   .CFG_VALUE(8'h00), .MAX_RETRY(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_last(cmd_last),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
      .fix_temp_tvalid(tvalid), .fix_temp_tdata(tdata),
      .err(err), .overrun(overrun), .busy(busy));

   adt7420_sched #(.INTERVAL(TT * 10), .CLK_PER(10), .I2C_ADDR(7'h4B),
                   .CFG_VALUE(8'h80), .MAX_RETRY(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
      .cmd_data(cmd_data_b), .cmd_last(cmd_last_b),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_nack(rsp_nack_b),
      .fix_temp_tvalid(tvalid_b), .fix_temp_tdata(tdata_b),
      .err(err_b), .overrun(overrun_b), .busy(busy_b));

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int temp_b_cnt = 0;

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic       last;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [15:0] exp_temp[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [7:0] data, input logic last);
      cmd_t c;
      c.op = op; c.data = data; c.last = last;
      exp_cmd.push_back(c);
   endtask

   task automatic push_cfg();
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h96, 1'b0);
      push_cmd(2'd1, 8'h03, 1'b0);
      push_cmd(2'd1, 8'h00, 1'b0);
      push_cmd(2'd3, 8'h00, 1'b0);
   endtask

   task automatic push_rd();
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h96, 1'b0);
      push_cmd(2'd1, 8'h00, 1'b0);
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h97, 1'b0);
      push_cmd(2'd2, 8'h00, 1'b0);
      push_cmd(2'd2, 8'h00, 1'b1);
      push_cmd(2'd3, 8'h00, 1'b0);
   endtask

   task automatic push_abort();
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h96, 1'b0);
      push_cmd(2'd3, 8'h00, 1'b0);
   endtask

   // Inputs change 1 ns after the rising edge, away from monitor sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      step();
      while ((exp_cmd.size() != 0 || exp_temp.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d cmds / %0d results outstanding, required 0", name,
                  exp_cmd.size(), exp_temp.size());
      end
      repeat (3) step();
   endtask

   // Engine model for dut: response two edges after the handshake
   int         dly = 0;
   logic [1:0] p_op;
   logic [7:0] p_data;
   logic       p_last;
   always @(negedge clk) begin
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (!rst_n) begin
         dly = 0;
      end else begin
         if (dly != 0) begin
            dly--;
            if (dly == 0) begin
               rsp_valid = 1'b1;
               if (p_op == 2'd1 && p_data == 8'h96 && nack_left > 0) begin
                  rsp_nack = 1'b1;
                  nack_left--;
               end
               if (p_op == 2'd2) rsp_data = p_last ? rd_lsb : rd_msb;
            end
         end
         if (cmd_valid && cmd_ready) begin
            p_op = cmd_op; p_data = cmd_data; p_last = cmd_last;
            dly = 2;
         end
      end
   end

   // Engine model for dut_b: always ready, reads return 0xE4 then 0x00
   int         dly_b = 0;
   logic [1:0] pb_op;
   logic       pb_last;
   always @(negedge clk) begin
      rsp_valid_b = 1'b0; rsp_data_b = 8'h00;
      if (!rst_n) begin
         dly_b = 0;
      end else begin
         if (dly_b != 0) begin
            dly_b--;
            if (dly_b == 0) begin
               rsp_valid_b = 1'b1;
               if (pb_op == 2'd2) rsp_data_b = pb_last ? 8'h00 : 8'hE4;
            end
         end
         if (cmd_valid_b && cmd_ready_b) begin
            pb_op = cmd_op_b; pb_last = cmd_last_b;
            dly_b = 1;
         end
      end
   end

   // Command monitor
   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         if (exp_cmd.size() == 0) begin
            check("unexpected_cmd", {22'd0, cmd_op, cmd_data}, 32'hFFFF_FFFF);
         end else begin
            cmd_t e;
            e = exp_cmd.pop_front();
            check("cmd_op",   {30'd0, cmd_op},   {30'd0, e.op});
            check("cmd_data", {24'd0, cmd_data}, {24'd0, e.data});
            check("cmd_last", {31'd0, cmd_last}, {31'd0, e.last});
         end
      end
   end

   // Result / pulse monitors
   always @(negedge clk) begin
      if (rst_n && tvalid) begin
         if (exp_temp.size() == 0)
            check("unexpected_tvalid", {16'd0, tdata}, 32'hFFFF_FFFF);
         else
            check("fix_temp_tdata", {16'd0, tdata}, {16'd0, exp_temp.pop_front()});
      end
      if (rst_n && err)     err_cnt++;
      if (rst_n && overrun) ovr_cnt++;
      if (rst_n && tvalid_b) begin
         temp_b_cnt++;
         check("fix_temp_tdata_16b", {16'd0, tdata_b}, 32'h0000_E400);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (3) step();
      check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
      check("rst_busy",      {31'd0, busy}, 0);
      check("rst_tvalid",    {31'd0, tvalid}, 0);
      check("rst_tdata",     {16'd0, tdata}, 0);
      check("rst_cmd_op_data_last", {21'd0, cmd_op, cmd_data, cmd_last}, 0);
      check("rst_err_overrun", {30'd0, err, overrun}, 0);

      // Config program after reset release
      push_cfg();
      rst_n = 1'b1;
      step();
      check("cfg_edge1_cmd_valid", {31'd0, cmd_valid}, 0);
      check("cfg_edge1_busy",      {31'd0, busy}, 1);
      step();
      check("cfg_edge2_cmd_valid", {31'd0, cmd_valid}, 1);
      wait_idle("cfg", 3 * TT);

      // Plain 13-bit read
      rd_msb = 8'h0C; rd_lsb = 8'h80;
      push_rd(); exp_temp.push_back(16'h0190);
      wait_idle("rd_basic", 3 * TT);

      // Two address NACKs, third attempt succeeds
      rd_msb = 8'h19; rd_lsb = 8'h08; nack_left = 2;
      push_abort(); push_abort(); push_rd(); exp_temp.push_back(16'h0321);
      wait_idle("rd_retry", 3 * TT);
      check("retry_err_count", err_cnt, 0);

      // NACK on every attempt: three aborts, one err, no result
      nack_left = 3;
      push_abort(); push_abort(); push_abort();
      wait_idle("rd_giveup", 3 * TT);
      check("giveup_err_count", err_cnt, 1);
      check("giveup_nacks_used", nack_left, 0);

      // Next tick runs again; negative reading shifts in zeros
      rd_msb = 8'hFF; rd_lsb = 8'hF8;
      push_rd(); exp_temp.push_back(16'h1FFF);
      wait_idle("rd_after_err", 3 * TT);
      check("after_err_err_count", err_cnt, 1);

      // Engine stall across three tick periods
      rd_msb = 8'h01; rd_lsb = 8'h90;
      push_rd(); exp_temp.push_back(16'h0032);
      push_rd(); exp_temp.push_back(16'h0032);
      stall = 1'b1;
      n = 0;
      while (ovr_cnt < 2 && n < 4 * TT) begin step(); n++; end
      check("stall_overrun_reached", {31'd0, ovr_cnt >= 2}, 1);
      check("stall_busy", {31'd0, busy}, 1);
      check("stall_cmd_valid", {31'd0, cmd_valid}, 1);
      stall = 1'b0;
      wait_idle("stall_drain", 3 * TT);
      check("stall_overrun_count", ovr_cnt, 2);

      // Reset in the middle of the msb READ
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h96, 1'b0);
      push_cmd(2'd1, 8'h00, 1'b0);
      push_cmd(2'd0, 8'h00, 1'b0);
      push_cmd(2'd1, 8'h97, 1'b0);
      push_cmd(2'd2, 8'h00, 1'b0);
      n = 0;
      while (exp_cmd.size() != 0 && n < 3 * TT) begin step(); n++; end
      check("midread_reached", {31'd0, n < 3 * TT}, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_cmd_valid", {31'd0, cmd_valid}, 0);
      check("midrst_busy",      {31'd0, busy}, 0);
      check("midrst_tdata",     {16'd0, tdata}, 0);
      check("midrst_cmd_op_data_last", {21'd0, cmd_op, cmd_data, cmd_last}, 0);
      repeat (2) step();
      push_cfg();
      rst_n = 1'b1;
      step();
      check("rerun_edge1_cmd_valid", {31'd0, cmd_valid}, 0);
      step();
      check("rerun_edge2_cmd_valid", {31'd0, cmd_valid}, 1);
      check("rerun_cmd_op", {30'd0, cmd_op}, 0);
      wait_idle("cfg_rerun", 3 * TT);

      check("leftover_cmds",    exp_cmd.size(), 0);
      check("leftover_results", exp_temp.size(), 0);
      check("result_16b_seen",  {31'd0, temp_b_cnt != 0}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adt7420_sched.md
# adt7420_sched

Transaction scheduler for the ADT7420 temperature sensor on a shared byte-level I2C command engine.
- After reset it writes the sensor configuration register once.
- On every interval tick it then runs a pointer-set + repeated-start + 2-byte temperature read and presents the result on the fix_temp stream consumed by the temperature conversion path.
- It also handles slave NACKs with bounded retry, and records dropped intervals.

## Interface
- INTERVAL, 1000000000: read period in ns.
- CLK_PER, 10: clk period in ns; TIME_TICK = INTERVAL/CLK_PER cycles.
- I2C_ADDR, 7'h4B: sensor 7-bit address.
- CFG_VALUE, 8'h00: byte written to config register 0x03; bit 7 selects 16-bit resolution.
- MAX_RETRY, 3: attempts per transaction before giving up.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  out  1  command offered to I2C engine.
- cmd_ready  in  1  engine accepts command.
- cmd_op  out  2  0=START (repeated if bus held), 1=WRITE, 2=READ, 3=STOP.
- cmd_data  out  8  byte for WRITE, else 0.
- cmd_last  out  1  READ only: master NACKs this byte.
- rsp_valid  in  1  engine finished the accepted command (one-cycle pulse).
- rsp_data  in  8  byte received by READ.
- rsp_nack  in  1  WRITE only: slave did not acknowledge.
- fix_temp_tvalid  out  1  one-cycle result strobe.
- fix_temp_tdata  out  16  temperature, fixed-point 0.0625 °C (13-bit mode) or 0.0078 °C (16-bit mode).
- err  out  1  one-cycle pulse: transaction abandoned after MAX_RETRY.
- overrun  out  1  one-cycle pulse: tick dropped.
- busy  out  1  transaction in progress.

## Operation
- Step programs:
  - CFG: START; WRITE {I2C_ADDR,0}; WRITE 0x03; WRITE CFG_VALUE; STOP.
  - RD: START; WRITE {I2C_ADDR,0}; WRITE 0x00; START; WRITE {I2C_ADDR,1}; READ (cmd_last=0) -> msb; READ (cmd_last=1) -> lsb; STOP.
- States:
  - IDLE -> ISSUE: when cfg_done=0 or a tick is pending.
  - ISSUE: cmd_valid held, with stable op/data/last, until cmd_ready; -> WAIT_RSP.
  - WAIT_RSP, on rsp_valid:
    - WRITE with rsp_nack=1 -> ABORT.
    - last step of program -> DONE.
    - otherwise step+1 -> ISSUE.
  - ABORT: issue STOP and wait for its response (rsp_nack ignored); then retry+1.
    - retry < MAX_RETRY -> ISSUE at step 0.
    - otherwise pulse err, clear retry -> IDLE. Program stays unfinished: CFG is redone at the next tick; RD is skipped.
  - DONE:
    - CFG: set cfg_done.
    - RD: load fix_temp_tdata = CFG_VALUE[7] ? {msb,lsb} : {msb,lsb}>>3 (logical shift), pulse fix_temp_tvalid.
    - Clear retry -> IDLE.
- Tick pending flag:
  - Set by tick, cleared when RD starts from IDLE.
  - A tick while the flag is already set pulses overrun and is otherwise dropped.
  - A tick in the same cycle as the flag clears re-sets it.
- While cfg_done=0, ticks set pending; the CFG program is not interleaved.
- rsp_valid outside WAIT_RSP/ABORT-wait is ignored. rsp_nack on START/READ is ignored.
- cmd_ready outside ISSUE/ABORT-issue is ignored.

## Timing
- Reset values: cmd_valid 0, cmd_op 0, cmd_data 0, cmd_last 0, fix_temp_tvalid 0, fix_temp_tdata 0, err 0, overrun 0, busy 0, cfg_done 0, retry 0, tick counter 0, pending 0.
- All outputs are registered.
- cmd_valid rises at the 2nd rising clk after rst_n deasserts (CFG step 0).
- Command handshake at edge N -> response accepted no earlier than edge N+1.
- Response at edge M -> next cmd_valid high after edge M+1.
- STOP response at edge M -> fix_temp_tvalid high for exactly the cycle after edge M+1; tdata holds until the next DONE.
- busy is high from ISSUE entry through DONE exit.
- Tick timing: the counter runs 0..TIME_TICK-1 free from reset, and a tick fires when counter = TIME_TICK-1. The first tick comes TIME_TICK cycles after reset release.
- rst_n asserted mid-transaction: immediate return to reset values and cfg_done cleared; the CFG program reruns. A partial bus cycle is the engine's responsibility, since it shares rst_n.

## Structure
- Package adt7420_pkg holds:
  - i2c_op_t enum (START/WRITE/READ/STOP).
  - sched_state_t.
  - Step record typedef {op, data_sel, last}.
  - CFG/RD step-program constants.
  - Config register pointer 0x03 and temperature pointer 0x00.
- One sub-module, interval_timer (TIME_TICK parameter, clk, rst_n, tick out).

## Test plan
- Reset release, engine responds with no NACK -> 5 CFG commands: START, 0x96, 0x03, 0x00, STOP; busy drops; no fix_temp_tvalid.
- Tick with msb=0x0C, lsb=0x80, CFG_VALUE=0x00 -> RD sequence with bytes 0x96, 0x00, 0x97; fix_temp_tdata=0x0190, one-cycle tvalid.
- CFG_VALUE=0x80, msb=0xE4, lsb=0x00 -> fix_temp_tdata=0xE400.
- NACK on the address byte twice, then ACK -> two STOP aborts, third attempt completes, no err.
- NACK on every attempt with MAX_RETRY=3 -> 3 STOPs, one err pulse, no tvalid, next tick runs again.
- Engine stalls cmd_ready for 3 TIME_TICK periods -> one tick pending, overrun pulses twice; rst_n pulse mid-READ -> outputs return to reset values and CFG reruns.
